uart_tx_arb: RTL and testbench

- Shares one UART byte transmitter among N requesters.
- Arbitrates pending byte requests, round-robin by default.
- Launches one frame at a time with a single-cycle start strobe, then waits for the transmitter's busy signal to rise and fall.
- Enforces a minimum idle gap between frames and flags a transmitter that never starts.
- Sits between the application byte sources and the serial transmitter / baud generator pair.

---
 rtl/uart_tx_arb.sv | 132 +++++++++++++
 tb/tb_uart_tx_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART byte transmitter among N requesters.
// Pending requests are granted round-robin. A grant launches one frame
// with a single-cycle tx_start strobe. The arbiter then waits for tx_busy
// to rise and then fall, and holds off for a fixed idle gap before the
// next launch. err is a sticky flag that is set when the transmitter
// never raises tx_busy after a launch.
// Optional feature macro: UART_ARB_FIXED_PRIO_EN. When it is defined, the
// lowest-index request always wins and the round-robin pointer is held at 0.
module uart_tx_arb #(
  parameter int unsigned N        = 4,
  parameter int unsigned IW       = 2,
  parameter int unsigned GAP_CYC  = 16,
  parameter int unsigned START_TO = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [8*N-1:0]    req_data,
  output logic [N-1:0]      ack,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic [IW-1:0]     grant_idx,
  output logic              err,
  input  logic              err_clr
);

  localparam int unsigned MAXC = (GAP_CYC > START_TO) ? GAP_CYC : START_TO;
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t          state;
  logic [IW-1:0]   rr;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   rr_next;

  // Winner selection: first set request at or above the pointer, wrapping mod N.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    int            j;
    w = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    j = int'(p);
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (r[i]) w = IW'(i);
    end
`else
    // Scan from the farthest offset down so the nearest set bit wins.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      j = (int'(p) + i) % int'(N);
      if (r[j]) w = IW'(j);
    end
`endif
    return w;
  endfunction

  // Combinational winner and the pointer value that follows it.
  always_comb begin
    win     = pick(req, rr);
`ifdef UART_ARB_FIXED_PRIO_EN
    rr_next = '0;
`else
    rr_next = IW'((int'(win) + 1) % int'(N));
`endif
  end

  // Arbiter FSM. Every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      cnt       <= '0;
      ack       <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      grant_idx <= '0;
      err       <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      // A clear is overridden by a timeout set later in this block.
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            ack       <= N'(1) << win;
            tx_start  <= 1'b1;
            tx_data   <= req_data[int'(win)*8 +: 8];
            grant_idx <= win;
            rr        <= rr_next;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          cnt <= cnt + 1'b1;
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(START_TO - 1)) begin
            // The transmitter never started, so the byte is dropped.
            err   <= 1'b1;
            cnt   <= '0;
            state <= GAP;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(GAP_CYC - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb. A small transmitter model raises tx_busy
// dly cycles after it sees tx_start and holds it high for len cycles.
module tb_uart_tx_arb;
  localparam int unsigned N        = 4;
  localparam int unsigned IW       = 2;
  localparam int unsigned GAP_CYC  = 16;
  localparam int unsigned START_TO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy = 1'b0;
  logic           busy;
  logic [IW-1:0]  grant_idx;
  logic           err;
  logic           err_clr = 1'b0;

  uart_tx_arb #(.N(N), .IW(IW), .GAP_CYC(GAP_CYC), .START_TO(START_TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy),
    .grant_idx(grant_idx), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Transmitter model, stepped on the falling edge.
  bit mdl_en   = 1'b0;
  bit mdl_kill = 1'b0;
  int dly      = 3;
  int len      = 5;
  int mc       = -1;
  always @(negedge clk) begin
    if (mdl_kill) begin
      mc      = -1;
      tx_busy = 1'b0;
    end else if (mc >= 0) begin
      mc++;
      if (mc == dly) tx_busy = 1'b1;
      if (mc == dly + len) begin
        tx_busy = 1'b0;
        mc      = -1;
      end
    end else if (mdl_en && tx_start === 1'b1) begin
      mc = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    mdl_kill = 1'b1;
    req      = '0;
    err_clr  = 1'b0;
    tick(3);
    rst      = 1'b0;
    mdl_kill = 1'b0;
  endtask

  // Returns the cycle at which tx_start is seen, or -1 when the budget expires.
  task automatic wait_start(input string tag, input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      if (tx_start === 1'b1) begin
        t = cyc;
        break;
      end
      tick();
    end
    chk({tag, "_seen"}, 32'(t >= 0), 32'd1);
  endtask

  initial begin
    int t, t1, t2, t3, tr, acks, exp_w;
    logic [7:0] exp_d [N];

    // Reset values.
    do_reset();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_txd", 32'(tx_data), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_idx), 0);
    chk("rst_err", 32'(err), 0);

    // Single byte from requester 0.
    mdl_en = 1'b1; dly = 3; len = 100;
    req = 4'b0001; req_data[7:0] = 8'hA5;
    tick();
    t = cyc;
    chk("sb_ack", 32'(ack), 32'h1);
    chk("sb_start", 32'(tx_start), 1);
    chk("sb_txd", 32'(tx_data), 32'hA5);
    chk("sb_busy", 32'(busy), 1);
    req = '0;
    tick();
    chk("sb_ack_pulse", 32'(ack), 0);
    chk("sb_start_pulse", 32'(tx_start), 0);
    // tx_busy is low from t+103: 1 WAIT_DONE cycle and 16 GAP cycles, then IDLE.
    tick(118);
    chk("sb_gap_busy", 32'(busy), 1);
    tick();
    chk("sb_idle", 32'(busy), 0);

    // Contention: all four requesters hold req and change data in their ack cycle.
    do_reset();
    dly = 3; len = 5;
    for (int k = 0; k < int'(N); k++) begin
      exp_d[k] = 8'(8'h10 * (k + 1));
      req_data[k*8 +: 8] = exp_d[k];
    end
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_start("cont", 100, t);
`ifdef UART_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = i % int'(N);
`endif
      chk("cont_ack", 32'(ack), 32'(1) << exp_w);
      chk("cont_grant", 32'(grant_idx), 32'(exp_w));
      chk("cont_txd", 32'(tx_data), 32'(exp_d[exp_w]));
      exp_d[exp_w] = exp_d[exp_w] + 8'd1;
      req_data[exp_w*8 +: 8] = exp_d[exp_w];
      tick();
    end
    req = '0;

    // Back-to-back bytes from requester 2. Each launch follows the previous one
    // after dly+len busy cycles, 1 WAIT_DONE, GAP_CYC GAP and 1 IDLE cycle.
    do_reset();
    req = 4'b0100; req_data[23:16] = 8'h11;
    wait_start("b2b1", 60, t1);
    chk("b2b1_ack", 32'(ack), 32'h4);
    chk("b2b1_txd", 32'(tx_data), 32'h11);
    req_data[23:16] = 8'h22;
    tick();
    wait_start("b2b2", 60, t2);
    chk("b2b2_txd", 32'(tx_data), 32'h22);
    chk("b2b2_gap", 32'(t2 - t1), 32'(3 + 5 + 16 + 2));
    req_data[23:16] = 8'h33;
    tick();
    wait_start("b2b3", 60, t3);
    chk("b2b3_txd", 32'(tx_data), 32'h33);
    chk("b2b3_gap", 32'(t3 - t2), 32'(3 + 5 + 16 + 2));
    req = '0;
    tick();

    // Start timeout: tx_busy never rises.
    do_reset();
    mdl_en = 1'b0;
    req = 4'b0010; req_data[15:8] = 8'h5A;
    wait_start("to", 10, t);
    chk("to_ack", 32'(ack), 32'h2);
    chk("to_txd", 32'(tx_data), 32'h5A);
    req = '0;
    acks = 0;
    for (int k = 0; k < 63; k++) begin
      tick();
      if (ack !== '0) acks++;
    end
    chk("to_err_early", 32'(err), 0);
    tick();
    chk("to_err_set", 32'(err), 1);
    chk("to_gap_busy", 32'(busy), 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ack !== '0) acks++;
    end
    chk("to_gap_end_busy", 32'(busy), 1);
    tick();
    chk("to_idle", 32'(busy), 0);
    chk("to_no_reack", 32'(acks), 0);
    chk("to_err_sticky", 32'(err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(err), 0);
    // Next request is still serviced; a clear coinciding with a timeout loses.
    req = 4'b0001; req_data[7:0] = 8'h96;
    wait_start("to2", 10, t);
    chk("to2_ack", 32'(ack), 32'h1);
    chk("to2_txd", 32'(tx_data), 32'h96);
    req = '0;
    tick(63);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to2_set_wins", 32'(err), 1);
    tick();
    chk("to2_err_hold", 32'(err), 1);

    // Reset during WAIT_DONE.
    do_reset();
    mdl_en = 1'b1; dly = 3; len = 50;
    req = 4'b1000; req_data[31:24] = 8'hC3;
    wait_start("rm", 10, t);
    chk("rm_grant", 32'(grant_idx), 32'h3);
    req = '0;
    tick(10);
    chk("rm_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_ack", 32'(ack), 0);
    chk("rm_txd", 32'(tx_data), 0);
    chk("rm_start", 32'(tx_start), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_grant0", 32'(grant_idx), 0);
    chk("rm_err", 32'(err), 0);
    tick(60);
    len = 5;
    req = 4'b0001; req_data[7:0] = 8'h77;
    tr = cyc;
    wait_start("rm2", 10, t);
    chk("rm2_latency", 32'(t - tr), 1);
    chk("rm2_ack", 32'(ack), 32'h1);
    chk("rm2_txd", 32'(tx_data), 32'h77);
    req = '0;
    tick(40);

    // tx_busy rises when the counter is at START_TO-2: no timeout.
    do_reset();
    dly = int'(START_TO) - 2; len = 4;
    req = 4'b0010; req_data[15:8] = 8'h3C;
    wait_start("late", 10, t);
    chk("late_txd", 32'(tx_data), 32'h3C);
    req = '0;
    tick(64);
    chk("late_no_err", 32'(err), 0);
    chk("late_busy", 32'(busy), 1);
    // tx_busy falls at t+66, so busy drops at t+83.
    tick(18);
    chk("late_gap_busy", 32'(busy), 1);
    tick();
    chk("late_idle", 32'(busy), 0);
    chk("late_err_final", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
